// File: rtl/memory_stage_unit.sv
// MEM pipeline stage: issues one data-memory request per load/store, waits
// for mem_ack with a bounded timeout, and feeds the MEM/WB register.
module memory_stage_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  wb_ctlout,
  input  logic [2:0]  m_ctlout,
  input  logic [31:0] add_result,
  input  logic        zero,
  input  logic [31:0] aluresult,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        mem_err,
  output logic [1:0]  mem_wb_ctl,
  output logic [31:0] mem_wb_rdata,
  output logic [31:0] mem_wb_alu,
  output logic [4:0]  mem_wb_rd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_err_q, mem_err_d;
  logic [1:0]  wb_ctl_q, wb_ctl_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [4:0]  wb_rd_q, wb_rd_d;

  logic access;

  assign access = m_ctlout[1] | m_ctlout[0];

  // Pipeline handshake: hold upstream while an access is launched or pending.
  always_comb begin
    stall         = ((state_q == S_IDLE) && access) || (state_q == S_WAIT);
    pcsrc         = m_ctlout[2] & zero & ~stall;
    branch_target = add_result;
  end

  // Next-state, memory request and MEM/WB load; MEM/WB defaults to a bubble.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_err_d   = mem_err_q;
    wb_ctl_d    = '0;
    wb_rdata_d  = '0;
    wb_alu_d    = '0;
    wb_rd_d     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (access) begin
          mem_req_d   = 1'b1;
          mem_we_d    = m_ctlout[0];
          mem_addr_d  = aluresult;
          mem_wdata_d = rdata2out;
          cnt_d       = '0;
          state_d     = S_WAIT;
        end else begin
          wb_ctl_d = wb_ctlout;
          wb_alu_d = aluresult;
          wb_rd_d  = five_bit_muxout;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          wb_ctl_d   = wb_ctlout;
          wb_rdata_d = mem_we_q ? '0 : mem_rdata;
          wb_alu_d   = aluresult;
          wb_rd_d    = five_bit_muxout;
          state_d    = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        // EX/MEM still shows the finished access this cycle; a bubble
        // keeps it from being written back a second time.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_err_q   <= 1'b0;
      wb_ctl_q    <= '0;
      wb_rdata_q  <= '0;
      wb_alu_q    <= '0;
      wb_rd_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_err_q   <= mem_err_d;
      wb_ctl_q    <= wb_ctl_d;
      wb_rdata_q  <= wb_rdata_d;
      wb_alu_q    <= wb_alu_d;
      wb_rd_q     <= wb_rd_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_err      = mem_err_q;
  assign mem_wb_ctl   = wb_ctl_q;
  assign mem_wb_rdata = wb_rdata_q;
  assign mem_wb_alu   = wb_alu_q;
  assign mem_wb_rd    = wb_rd_q;

endmodule

// File: tb/tb_memory_stage_unit.sv
// Self-checking bench for memory_stage_unit (TIMEOUT=4): expected per-edge
// register contents are queued as each cycle is driven and popped after it.
module tb_memory_stage_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wb_ctlout;
  logic [2:0]  m_ctlout;
  logic [31:0] add_result;
  logic        zero;
  logic [31:0] aluresult;
  logic [31:0] rdata2out;
  logic [4:0]  five_bit_muxout;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall, pcsrc;
  logic [31:0] branch_target;
  logic        mem_err;
  logic [1:0]  mem_wb_ctl;
  logic [31:0] mem_wb_rdata, mem_wb_alu;
  logic [4:0]  mem_wb_rd;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned stall_cnt;

  typedef struct {
    logic [1:0]  ctl;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        req;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  memory_stage_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout),
    .add_result(add_result), .zero(zero), .aluresult(aluresult),
    .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .pcsrc(pcsrc), .branch_target(branch_target),
    .mem_err(mem_err), .mem_wb_ctl(mem_wb_ctl), .mem_wb_rdata(mem_wb_rdata),
    .mem_wb_alu(mem_wb_alu), .mem_wb_rd(mem_wb_rd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] ctl, input logic [31:0] rdata,
                              input logic [31:0] alu, input logic [4:0] rd,
                              input logic req, input logic err);
    exp_t e;
    e.ctl = ctl; e.rdata = rdata; e.alu = alu; e.rd = rd; e.req = req; e.err = err;
    return e;
  endfunction

  function automatic exp_t bubble(input logic req, input logic err);
    return mk(2'd0, 32'd0, 32'd0, 5'd0, req, err);
  endfunction

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  // Queue the expected post-edge state, clock once, then compare.
  task automatic cyc(input string tag, input exp_t e);
    exp_t got;
    sb_q.push_back(e);
    if (stall) stall_cnt++;
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_eq({tag, ".wb_ctl"},   64'(mem_wb_ctl),   64'(got.ctl));
    check_eq({tag, ".wb_rdata"}, 64'(mem_wb_rdata), 64'(got.rdata));
    check_eq({tag, ".wb_alu"},   64'(mem_wb_alu),   64'(got.alu));
    check_eq({tag, ".wb_rd"},    64'(mem_wb_rd),    64'(got.rd));
    check_eq({tag, ".req"},      64'(mem_req),      64'(got.req));
    check_eq({tag, ".err"},      64'(mem_err),      64'(got.err));
  endtask

  initial begin
    reset = 1'b0; wb_ctlout = '0; m_ctlout = '0; add_result = '0; zero = 1'b0;
    aluresult = '0; rdata2out = '0; five_bit_muxout = '0; mem_ack = 1'b0;
    mem_rdata = '0;

    // Reset
    cyc("rst", bubble(1'b0, 1'b0));
    check_eq("rst.we", 64'(mem_we), 64'd0);
    check_eq("rst.addr", 64'(mem_addr), 64'd0);
    check_eq("rst.wdata", 64'(mem_wdata), 64'd0);
    m_ctlout = 3'b010; settle();
    check_eq("rst.stall_idle_access", 64'(stall), 64'd1);
    m_ctlout = 3'b000; settle();
    check_eq("rst.stall_idle", 64'(stall), 64'd0);
    reset = 1'b1;

    // ALU op passes straight through in one cycle
    wb_ctlout = 2'b10; aluresult = 32'h1234; five_bit_muxout = 5'd5; settle();
    check_eq("alu.stall", 64'(stall), 64'd0);
    cyc("alu", mk(2'b10, 32'd0, 32'h1234, 5'd5, 1'b0, 1'b0));

    // Load, ack in first WAIT cycle
    stall_cnt = 0;
    wb_ctlout = 2'b01; m_ctlout = 3'b010; aluresult = 32'h40; five_bit_muxout = 5'd7;
    rdata2out = 32'h55; settle();
    check_eq("ld.stall0", 64'(stall), 64'd1);
    cyc("ld.issue", bubble(1'b1, 1'b0));
    check_eq("ld.addr", 64'(mem_addr), 64'h40);
    check_eq("ld.we", 64'(mem_we), 64'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; settle();
    check_eq("ld.stall1", 64'(stall), 64'd1);
    cyc("ld.ack", mk(2'b01, 32'hDEADBEEF, 32'h40, 5'd7, 1'b0, 1'b0));
    mem_ack = 1'b0; settle();
    check_eq("ld.stall_done", 64'(stall), 64'd0);
    cyc("ld.done", bubble(1'b0, 1'b0));
    check_eq("ld.stall_cycles", 64'(stall_cnt), 64'd2);

    // Stray ack in IDLE is ignored
    m_ctlout = 3'b000; wb_ctlout = 2'b11; aluresult = 32'h77; five_bit_muxout = 5'd9;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000; settle();
    cyc("idle_ack", mk(2'b11, 32'd0, 32'h77, 5'd9, 1'b0, 1'b0));
    mem_ack = 1'b0;

    // Store, ack in the 4th WAIT cycle (last one before timeout)
    stall_cnt = 0;
    wb_ctlout = 2'b00; m_ctlout = 3'b001; aluresult = 32'h100; rdata2out = 32'hCAFE;
    five_bit_muxout = 5'd0; settle();
    cyc("st.issue", bubble(1'b1, 1'b0));
    rdata2out = 32'hBAD0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("st.we", 64'(mem_we), 64'd1);
      check_eq("st.wdata", 64'(mem_wdata), 64'hCAFE);
      check_eq("st.addr", 64'(mem_addr), 64'h100);
      cyc("st.wait", bubble(1'b1, 1'b0));
    end
    mem_ack = 1'b1; mem_rdata = 32'h1111; settle();
    check_eq("st.wdata_last", 64'(mem_wdata), 64'hCAFE);
    cyc("st.ack", mk(2'b00, 32'd0, 32'h100, 5'd0, 1'b0, 1'b0));
    mem_ack = 1'b0; settle();
    cyc("st.done", bubble(1'b0, 1'b0));
    check_eq("st.stall_cycles", 64'(stall_cnt), 64'd5);

    // memread and memwrite together is a write
    m_ctlout = 3'b011; aluresult = 32'h204; rdata2out = 32'h99; wb_ctlout = 2'b01;
    five_bit_muxout = 5'd4; settle();
    cyc("rw.issue", bubble(1'b1, 1'b0));
    check_eq("rw.we", 64'(mem_we), 64'd1);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678; settle();
    cyc("rw.ack", mk(2'b01, 32'd0, 32'h204, 5'd4, 1'b0, 1'b0));
    mem_ack = 1'b0; settle();
    cyc("rw.done", bubble(1'b0, 1'b0));

    // Load with no ack times out after 4 WAIT cycles
    m_ctlout = 3'b010; aluresult = 32'h200; wb_ctlout = 2'b01; five_bit_muxout = 5'd8;
    settle();
    cyc("to.issue", bubble(1'b1, 1'b0));
    for (int i = 0; i < 3; i++) cyc("to.wait", bubble(1'b1, 1'b0));
    cyc("to.abort", bubble(1'b0, 1'b1));
    settle();
    check_eq("to.stall_done", 64'(stall), 64'd0);
    cyc("to.done", bubble(1'b0, 1'b1));

    // Sticky error, later accesses still work
    m_ctlout = 3'b000; wb_ctlout = 2'b11; aluresult = 32'h300; five_bit_muxout = 5'd3;
    settle();
    cyc("post_to.alu", mk(2'b11, 32'd0, 32'h300, 5'd3, 1'b0, 1'b1));
    m_ctlout = 3'b010; aluresult = 32'h44; wb_ctlout = 2'b01; five_bit_muxout = 5'd2;
    settle();
    cyc("post_to.issue", bubble(1'b1, 1'b1));
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_5A5A; settle();
    cyc("post_to.ack", mk(2'b01, 32'hA5A5_5A5A, 32'h44, 5'd2, 1'b0, 1'b1));
    mem_ack = 1'b0; settle();
    cyc("post_to.done", bubble(1'b0, 1'b1));

    // Branch resolution
    m_ctlout = 3'b100; zero = 1'b1; add_result = 32'h80; aluresult = 32'h0;
    wb_ctlout = 2'b00; five_bit_muxout = 5'd0; settle();
    check_eq("br.pcsrc_taken", 64'(pcsrc), 64'd1);
    check_eq("br.target", 64'(branch_target), 64'h80);
    zero = 1'b0; settle();
    check_eq("br.pcsrc_not_taken", 64'(pcsrc), 64'd0);
    m_ctlout = 3'b110; zero = 1'b1; settle();
    check_eq("br.pcsrc_stalled", 64'(pcsrc), 64'd0);
    m_ctlout = 3'b100; settle();
    cyc("br", mk(2'b00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));
    zero = 1'b0;

    // Reset mid-WAIT with a simultaneous ack
    m_ctlout = 3'b010; aluresult = 32'h500; wb_ctlout = 2'b01; five_bit_muxout = 5'd6;
    rdata2out = 32'h66; settle();
    cyc("rstw.issue", bubble(1'b1, 1'b1));
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D; settle();
    cyc("rstw", bubble(1'b0, 1'b0));
    check_eq("rstw.we", 64'(mem_we), 64'd0);
    check_eq("rstw.addr", 64'(mem_addr), 64'd0);
    check_eq("rstw.wdata", 64'(mem_wdata), 64'd0);
    mem_ack = 1'b0; settle();
    check_eq("rstw.idle_stall", 64'(stall), 64'd1);
    reset = 1'b1; m_ctlout = 3'b000; aluresult = 32'h600; wb_ctlout = 2'b10;
    five_bit_muxout = 5'd1; settle();
    check_eq("rstw.stall_clear", 64'(stall), 64'd0);
    cyc("rstw.alu", mk(2'b10, 32'd0, 32'h600, 5'd1, 1'b0, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
